i2c_slave_responder: RTL and testbench

Clock-oversampled I2C target (responder) sitting on the same SCL/SDA bus as the team's `i2c_master`. It detects START/STOP, shifts in a 7-bit address plus R/W bit and ACKs when the address matches `SLAVE_ADDR`. For writes it delivers each received byte to the fabric and ACKs it; for reads it fetches bytes from the fabric and shifts them out. SDA is driven open-drain only (low or high-Z); SCL is input-only, with no clock stretching.

---
 rtl/i2c_slave_responder.sv | 213 +++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_responder.sv
// ============================================================================
//  Module      : i2c_slave_responder
//  Description : Clock-oversampled I2C target that answers one 7-bit address.
//                Write bytes go out on rx_data and read bytes come in from
//                tx_data. SDA is driven open-drain and SCL is never stretched.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACK_ADDR,
        S_RX_BYTE,
        S_ACK_RX,
        S_TX_BYTE,
        S_ACK_TX,
        S_WAIT_STOP
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] scl_sync_q;
    logic [2:0] sda_sync_q;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       full_q, full_d;
    logic [7:0] shift_q, shift_d;
    logic [6:0] tx_shift_q, tx_shift_d;
    logic       rw_q, rw_d;
    logic       oe_q, oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_load_q, tx_load_d;
    logic       busy_q, busy_d;

    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    // The synchronizers keep sampling through reset so they hold real bus
    // levels when reset drops and cannot fabricate a START or STOP.
    always_ff @(posedge clk) begin
        scl_sync_q <= {scl_sync_q[1:0], scl};
        sda_sync_q <= {sda_sync_q[1:0], sda};
    end

    assign w_scl_rise = scl_sync_q[1] & ~scl_sync_q[2];
    assign w_scl_fall = ~scl_sync_q[1] & scl_sync_q[2];
    assign w_start    = sda_sync_q[2] & ~sda_sync_q[1] & scl_sync_q[1] & scl_sync_q[2];
    assign w_stop     = ~sda_sync_q[2] & sda_sync_q[1] & scl_sync_q[1] & scl_sync_q[2];

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        full_d     = full_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        rw_d       = rw_q;
        oe_d       = oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;
        busy_d     = busy_q;

        if (w_start) begin
            state_d  = S_ADDR;
            bitcnt_d = 3'd0;
            full_d   = 1'b0;
            oe_d     = 1'b0;
        end else if (w_stop) begin
            state_d = S_IDLE;
            full_d  = 1'b0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_RX_BYTE: begin
                    if (w_scl_rise) begin
                        shift_d  = {shift_q[6:0], sda_sync_q[1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            full_d = 1'b1;
                        end
                    end else if (w_scl_fall && full_q) begin
                        full_d = 1'b0;
                        if (state_q == S_RX_BYTE) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            oe_d       = 1'b1;
                            state_d    = S_ACK_RX;
                        end else if (shift_q[7:1] == SLAVE_ADDR) begin
                            rw_d    = shift_q[0];
                            oe_d    = 1'b1;
                            state_d = S_ACK_ADDR;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = S_WAIT_STOP;
                        end
                    end
                end
                S_ACK_ADDR: begin
                    if (w_scl_fall) begin
                        busy_d   = 1'b1;
                        bitcnt_d = 3'd0;
                        full_d   = 1'b0;
                        if (rw_q) begin
                            tx_shift_d = tx_data[6:0];
                            tx_load_d  = 1'b1;
                            oe_d       = ~tx_data[7];
                            state_d    = S_TX_BYTE;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = S_RX_BYTE;
                        end
                    end
                end
                S_ACK_RX: begin
                    if (w_scl_fall) begin
                        oe_d     = 1'b0;
                        bitcnt_d = 3'd0;
                        full_d   = 1'b0;
                        state_d  = S_RX_BYTE;
                    end
                end
                S_TX_BYTE: begin
                    if (w_scl_rise) begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            full_d = 1'b1;
                        end
                    end else if (w_scl_fall) begin
                        if (full_q) begin
                            full_d  = 1'b0;
                            oe_d    = 1'b0;
                            state_d = S_ACK_TX;
                        end else begin
                            oe_d       = ~tx_shift_q[6];
                            tx_shift_d = {tx_shift_q[5:0], 1'b0};
                        end
                    end
                end
                S_ACK_TX: begin
                    // full_q marks a sampled master ACK awaiting the next SCL fall.
                    if (w_scl_rise) begin
                        if (sda_sync_q[1]) begin
                            state_d = S_WAIT_STOP;
                        end else begin
                            full_d = 1'b1;
                        end
                    end else if (w_scl_fall && full_q) begin
                        full_d     = 1'b0;
                        bitcnt_d   = 3'd0;
                        tx_shift_d = tx_data[6:0];
                        tx_load_d  = 1'b1;
                        oe_d       = ~tx_data[7];
                        state_d    = S_TX_BYTE;
                    end
                end
                default: begin
                    oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bitcnt_q   <= 3'd0;
            full_q     <= 1'b0;
            shift_q    <= 8'h00;
            tx_shift_q <= 7'h00;
            rw_q       <= 1'b0;
            oe_q       <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            full_q     <= full_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rw_q       <= rw_d;
            oe_q       <= oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_load_q  <= tx_load_d;
            busy_q     <= busy_d;
        end
    end

    assign sda      = oe_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_load  = tx_load_q;
    assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_responder.sv
// ============================================================================
//  Module      : tb_i2c_slave_responder
//  Description : Directed bus-master bench for i2c_slave_responder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_i2c_slave_responder;

    localparam int Q = 6;

    logic       clk;
    logic       reset;
    logic       scl;
    logic       m_low;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       busy;

    int total;
    int bad;

    int         rx_cnt;
    int         txl_cnt;
    int         both_cnt;
    int         wide_cnt;
    logic       rx_valid_prev;
    logic       tx_load_prev;
    logic [7:0] rx_log  [16];
    logic [7:0] tx_list [4];

    pullup (sda);
    assign sda     = m_low ? 1'b0 : 1'bz;
    assign tx_data = tx_list[txl_cnt[1:0]];

    i2c_slave_responder #(.SLAVE_ADDR(7'h50)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda      (sda),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rx_cnt        = 0;
        txl_cnt       = 0;
        both_cnt      = 0;
        wide_cnt      = 0;
        rx_valid_prev = 1'b0;
        tx_load_prev  = 1'b0;
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt[3:0]] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (tx_load) txl_cnt <= txl_cnt + 1;
        if (rx_valid && tx_load) both_cnt <= both_cnt + 1;
        if ((rx_valid && rx_valid_prev) || (tx_load && tx_load_prev)) wide_cnt <= wide_cnt + 1;
        rx_valid_prev <= rx_valid;
        tx_load_prev  <= tx_load;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mbit(input logic b, output logic rb);
        wait_clk(2);
        m_low = ~b;
        wait_clk(Q - 2);
        scl = 1'b1;
        wait_clk(Q);
        rb = sda;
        wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic m_start();
        if (scl == 1'b0) begin
            wait_clk(2);
            m_low = 1'b0;
            wait_clk(Q - 2);
            scl = 1'b1;
            wait_clk(Q);
        end
        m_low = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic m_stop();
        wait_clk(2);
        m_low = 1'b1;
        wait_clk(Q - 2);
        scl = 1'b1;
        wait_clk(Q);
        m_low = 1'b0;
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) mbit(b[i], d);
        mbit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] v);
        logic rb;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            mbit(1'b1, rb);
            v = {v[6:0], rb};
        end
        mbit(nack, rb);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        scl   = 1'b1;
        m_low = 1'b0;
        tx_list[0] = 8'h00; tx_list[1] = 8'h00; tx_list[2] = 8'h00; tx_list[3] = 8'h00;
        wait_clk(6);
        reset = 1'b0;
        wait_clk(4);
        total++; if (sda !== 1'b1)      begin bad++; $display("FAIL reset_sda got=%b exp=1", sda); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        total++; if (tx_load !== 1'b0)  begin bad++; $display("FAIL reset_tx_load got=%b exp=0", tx_load); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_write();
        logic ack;
        int   r0;
        r0 = rx_cnt;
        m_start();
        write_byte(8'hA0, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL wr_addr_ack got=%b exp=0", ack); end
        write_byte(8'hA5, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL wr_data_ack got=%b exp=0", ack); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b exp=1", busy); end
        m_stop();
        total++; if (rx_cnt !== r0 + 1) begin bad++; $display("FAIL wr_rx_count got=%0d exp=%0d", rx_cnt, r0 + 1); end
        total++; if (rx_log[r0 & 15] !== 8'hA5) begin bad++; $display("FAIL wr_rx_byte got=%h exp=a5", rx_log[r0 & 15]); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL wr_rx_data got=%h exp=a5", rx_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_after_stop got=%b exp=0", busy); end
    endtask

    task automatic test_mismatch();
        logic ack;
        int   r0;
        r0 = rx_cnt;
        m_start();
        write_byte(8'hA2, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL mis_addr_ack got=%b exp=1", ack); end
        write_byte(8'h3C, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL mis_data_ack got=%b exp=1", ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mis_busy got=%b exp=0", busy); end
        m_stop();
        total++; if (rx_cnt !== r0) begin bad++; $display("FAIL mis_rx_count got=%0d exp=%0d", rx_cnt, r0); end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] v;
        int         t0;
        t0 = txl_cnt;
        tx_list[t0 & 3]       = 8'hC3;
        tx_list[(t0 + 1) & 3] = 8'h5A;
        m_start();
        write_byte(8'hA1, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rd_addr_ack got=%b exp=0", ack); end
        read_byte(1'b0, v);
        total++; if (v !== 8'hC3) begin bad++; $display("FAIL rd_byte0 got=%h exp=c3", v); end
        read_byte(1'b1, v);
        total++; if (v !== 8'h5A) begin bad++; $display("FAIL rd_byte1 got=%h exp=5a", v); end
        wait_clk(Q);
        total++; if (sda !== 1'b1) begin bad++; $display("FAIL rd_release got=%b exp=1", sda); end
        total++; if (txl_cnt !== t0 + 2) begin bad++; $display("FAIL rd_tx_loads got=%0d exp=%0d", txl_cnt, t0 + 2); end
        m_stop();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_busy_after_stop got=%b exp=0", busy); end
    endtask

    task automatic test_repeated_start();
        logic       ack;
        logic [7:0] v;
        int         r0;
        r0 = rx_cnt;
        tx_list[txl_cnt & 3] = 8'h96;
        m_start();
        write_byte(8'hA0, ack);
        write_byte(8'h11, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rs_data_ack got=%b exp=0", ack); end
        m_start();
        write_byte(8'hA1, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rs_addr_ack got=%b exp=0", ack); end
        read_byte(1'b1, v);
        total++; if (v !== 8'h96) begin bad++; $display("FAIL rs_read got=%h exp=96", v); end
        m_stop();
        total++; if (rx_cnt !== r0 + 1) begin bad++; $display("FAIL rs_rx_count got=%0d exp=%0d", rx_cnt, r0 + 1); end
        total++; if (rx_log[r0 & 15] !== 8'h11) begin bad++; $display("FAIL rs_rx_byte got=%h exp=11", rx_log[r0 & 15]); end
    endtask

    task automatic test_reset_mid();
        logic ack;
        logic d;
        int   r0;
        r0 = rx_cnt;
        m_start();
        write_byte(8'hA0, ack);
        for (int i = 0; i < 4; i++) mbit(1'b1, d);
        m_low = 1'b0;
        reset = 1'b1;
        wait_clk(1);
        total++; if (sda !== 1'b1) begin bad++; $display("FAIL rstmid_sda got=%b exp=1", sda); end
        wait_clk(2);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) mbit(1'b0, d);
        mbit(1'b1, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL rstmid_no_rejoin got=%b exp=1", ack); end
        m_stop();
        total++; if (rx_cnt !== r0) begin bad++; $display("FAIL rstmid_rx_count got=%0d exp=%0d", rx_cnt, r0); end
        m_start();
        write_byte(8'hA0, ack);
        write_byte(8'h5C, ack);
        m_stop();
        total++; if (rx_data !== 8'h5C) begin bad++; $display("FAIL rstmid_after got=%h exp=5c", rx_data); end
        // Reset while the responder is actively pulling SDA for the address ACK.
        m_start();
        for (int i = 7; i >= 0; i--) mbit(i == 7 || i == 5, d);
        m_low = 1'b0;
        wait_clk(Q);
        total++; if (sda !== 1'b0) begin bad++; $display("FAIL rstack_driven got=%b exp=0", sda); end
        reset = 1'b1;
        wait_clk(1);
        total++; if (sda !== 1'b1) begin bad++; $display("FAIL rstack_release got=%b exp=1", sda); end
        wait_clk(2);
        reset = 1'b0;
        m_stop();
    endtask

    task automatic test_stop_mid();
        logic ack;
        logic d;
        int   r0;
        r0 = rx_cnt;
        m_start();
        write_byte(8'hA0, ack);
        mbit(1'b1, d);
        mbit(1'b0, d);
        mbit(1'b1, d);
        m_stop();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stopmid_busy got=%b exp=0", busy); end
        scl = 1'b0;
        write_byte(8'hFF, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL stopmid_idle_ack got=%b exp=1", ack); end
        m_stop();
        total++; if (rx_cnt !== r0) begin bad++; $display("FAIL stopmid_rx_count got=%0d exp=%0d", rx_cnt, r0); end
    endtask

    task automatic test_multi_byte();
        logic       ack;
        logic [7:0] bytes [3];
        int         r0;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h80;
        r0 = rx_cnt;
        m_start();
        write_byte(8'hA0, ack);
        for (int k = 0; k < 3; k++) begin
            write_byte(bytes[k], ack);
            total++; if (ack !== 1'b0) begin bad++; $display("FAIL multi_ack%0d got=%b exp=0", k, ack); end
        end
        m_stop();
        total++; if (rx_cnt !== r0 + 3) begin bad++; $display("FAIL multi_rx_count got=%0d exp=%0d", rx_cnt, r0 + 3); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rx_log[(r0 + k) & 15] !== bytes[k]) begin
                bad++; $display("FAIL multi_byte%0d got=%h exp=%h", k, rx_log[(r0 + k) & 15], bytes[k]);
            end
        end
    endtask

    task automatic test_pulse_shape();
        total++; if (wide_cnt !== 0) begin bad++; $display("FAIL pulse_width got=%0d exp=0", wide_cnt); end
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL pulse_overlap got=%0d exp=0", both_cnt); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_repeated_start();
        test_reset_mid();
        test_stop_mid();
        test_multi_byte();
        test_pulse_shape();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
